// File: rtl/mmm_pkg.sv
// Shared types and sizing helpers for the parallel-lane matrix multiplier.
package mmm_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic valid;
      logic clear;
      logic last;
   } sb_t;

   // Never returns 0 so a degenerate size still yields a legal 1-bit vector.
   function automatic int clog2_safe(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   function automatic int num_groups(input int n, input int p);
      return (n + p - 1) / p;
   endfunction

   function automatic int last_lanes(input int n, input int p);
      return n - p * (num_groups(n, p) - 1);
   endfunction

endpackage

// File: rtl/mmm_lane.sv
// One MAC lane: registered signed product, then a wrapping accumulator.
module mmm_lane #(
   parameter int INW  = 12,
   parameter int OUTW = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   input  logic            in_clear,
   input  logic [INW-1:0]  a_in,
   input  logic [INW-1:0]  b_in,
   output logic [OUTW-1:0] acc_out
);

   logic signed [2*INW-1:0] prod_d, prod_q;
   logic                    vld_q, clr_q;
   logic [OUTW-1:0]         prod_ext, acc_d, acc_q;

   always_comb begin
      prod_d   = (2*INW)'($signed(a_in)) * (2*INW)'($signed(b_in));
      // Size cast of a signed value sign-extends or truncates as OUTW demands.
      prod_ext = OUTW'(prod_q);
      acc_d    = acc_q;
      if (vld_q) begin
         acc_d = clr_q ? prod_ext : acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prod_q <= '0;
         vld_q  <= 1'b0;
         clr_q  <= 1'b0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         vld_q  <= in_valid;
         clr_q  <= in_clear;
         acc_q  <= acc_d;
      end
   end

   assign acc_out = acc_q;

endmodule

// File: rtl/mmm_par.sv
// C = A*B with P parallel MAC lanes, credit-gated into a multi-write output
// buffer that feeds an AXI-Stream port.
module mmm_par
   import mmm_pkg::*;
#(
   parameter int INW       = 12,
   parameter int OUTW      = 32,
   parameter int M         = 7,
   parameter int N         = 9,
   parameter int MAXK      = 8,
   parameter int P         = 4,
   parameter int MEM_LAT   = 1,
   parameter int OUT_DEPTH = 2 * P,
   localparam int KW = clog2_safe(MAXK + 1),
   localparam int AW = clog2_safe(M * MAXK),
   localparam int BW = clog2_safe(MAXK * num_groups(N, P))
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             matrices_loaded,
   input  logic [KW-1:0]    K,
   output logic             compute_finished,
   output logic [AW-1:0]    a_addr,
   input  logic [INW-1:0]   a_data,
   output logic [BW-1:0]    b_addr,
   input  logic [P*INW-1:0] b_data,
   output logic [OUTW-1:0]  OUTPUT_TDATA,
   output logic             OUTPUT_TVALID,
   input  logic             OUTPUT_TREADY,
   output logic             busy
);

   localparam int G     = num_groups(N, P);
   localparam int LASTN = last_lanes(N, P);
   localparam int RW    = clog2_safe(M);
   localparam int GW    = clog2_safe(G);
   localparam int PW    = clog2_safe(OUT_DEPTH);
   localparam int CW    = clog2_safe(OUT_DEPTH + 1);
   localparam logic [P-1:0] LAST_MASK = P'((64'd1 << LASTN) - 64'd1);

   state_t          state_d, state_q;
   logic [KW-1:0]   k_d, k_q, kval_d, kval_q;
   logic [GW-1:0]   grp_d, grp_q;
   logic [RW-1:0]   row_d, row_q;
   logic [AW-1:0]   a_addr_d, a_addr_q;
   logic [BW-1:0]   b_addr_d, b_addr_q;
   logic            cf_d, cf_q, busy_q;
   logic            issue, pipe_busy;
   logic [CW-1:0]   issue_lanes;

   sb_t             sb_d [MEM_LAT+1];
   sb_t             sb_q [MEM_LAT+1];
   logic [P-1:0]    sb_mask_d [MEM_LAT+1];
   logic [P-1:0]    sb_mask_q [MEM_LAT+1];
   logic            p1_vld_q, p1_last_q, p2_vld_q, p2_last_q;
   logic [P-1:0]    p1_mask_q, p2_mask_q;

   logic [OUTW-1:0] acc [P];
   logic [OUTW-1:0] mem_q [OUT_DEPTH];
   logic [PW-1:0]   wr_idx [P];
   logic [PW-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic [CW-1:0]   count_d, count_q, credit_d, credit_q, wr_n;
   logic            do_write, beat;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [CW-1:0] inc);
      int s;
      s = int'(base) + int'(inc);
      if (s >= OUT_DEPTH) s = s - OUT_DEPTH;
      return PW'(s);
   endfunction

   // Sequencer: k innermost, then column group, then row.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      grp_d       = grp_q;
      row_d       = row_q;
      kval_d      = kval_q;
      a_addr_d    = a_addr_q;
      b_addr_d    = b_addr_q;
      cf_d        = 1'b0;
      issue       = 1'b0;
      issue_lanes = (grp_q == GW'(G - 1)) ? CW'(LASTN) : CW'(P);
      pipe_busy   = p1_vld_q | p2_vld_q;
      for (int i = 0; i <= MEM_LAT; i++) begin
         pipe_busy = pipe_busy | sb_q[i].valid;
      end

      case (state_q)
         IDLE: begin
            if (matrices_loaded) begin
               kval_d = K;
               if (K == '0) begin
                  state_d = DONE;
                  cf_d    = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Only the opening read of a group reserves buffer space.
            if (k_q != '0 || credit_q >= issue_lanes) begin
               issue    = 1'b1;
               a_addr_d = AW'(32'(row_q) * 32'(kval_q) + 32'(k_q));
               b_addr_d = BW'(32'(k_q) * 32'(G) + 32'(grp_q));
               if (k_q == kval_q - KW'(1)) begin
                  k_d = '0;
                  if (grp_q == GW'(G - 1)) begin
                     grp_d = '0;
                     if (row_q == RW'(M - 1)) begin
                        row_d   = '0;
                        state_d = DRAIN;
                     end else begin
                        row_d = row_q + RW'(1);
                     end
                  end else begin
                     grp_d = grp_q + GW'(1);
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         DRAIN: begin
            if (!pipe_busy) begin
               state_d = DONE;
               cf_d    = 1'b1;
            end
         end
         DONE: begin
            if (!matrices_loaded) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      sb_d[0]      = '{valid: issue, clear: (k_q == '0), last: (k_q == kval_q - KW'(1))};
      sb_mask_d[0] = (grp_q == GW'(G - 1)) ? LAST_MASK : '1;
      for (int i = 1; i <= MEM_LAT; i++) begin
         sb_d[i]      = sb_q[i-1];
         sb_mask_d[i] = sb_mask_q[i-1];
      end
   end

   always_comb begin
      wr_n = '0;
      for (int j = 0; j < P; j++) begin
         if (p2_mask_q[j]) wr_n = wr_n + CW'(1);
      end
      do_write = p2_vld_q & p2_last_q;
      beat     = OUTPUT_TVALID & OUTPUT_TREADY;
      wr_ptr_d = do_write ? wrap_add(wr_ptr_q, wr_n) : wr_ptr_q;
      rd_ptr_d = beat ? wrap_add(rd_ptr_q, CW'(1)) : rd_ptr_q;
      count_d  = count_q + (do_write ? wr_n : '0) - CW'(beat);
      credit_d = credit_q - ((issue && k_q == '0) ? issue_lanes : '0) + CW'(beat);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         kval_q    <= '0;
         grp_q     <= '0;
         row_q     <= '0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         cf_q      <= 1'b0;
         busy_q    <= 1'b0;
         for (int i = 0; i <= MEM_LAT; i++) begin
            sb_q[i]      <= '0;
            sb_mask_q[i] <= '0;
         end
         p1_vld_q  <= 1'b0;
         p1_last_q <= 1'b0;
         p1_mask_q <= '0;
         p2_vld_q  <= 1'b0;
         p2_last_q <= 1'b0;
         p2_mask_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         credit_q  <= CW'(OUT_DEPTH);
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         kval_q    <= kval_d;
         grp_q     <= grp_d;
         row_q     <= row_d;
         a_addr_q  <= a_addr_d;
         b_addr_q  <= b_addr_d;
         cf_q      <= cf_d;
         busy_q    <= (state_d != IDLE);
         for (int i = 0; i <= MEM_LAT; i++) begin
            sb_q[i]      <= sb_d[i];
            sb_mask_q[i] <= sb_mask_d[i];
         end
         // Follow the lanes' product and accumulate stages.
         p1_vld_q  <= sb_q[MEM_LAT].valid;
         p1_last_q <= sb_q[MEM_LAT].last;
         p1_mask_q <= sb_mask_q[MEM_LAT];
         p2_vld_q  <= p1_vld_q;
         p2_last_q <= p1_last_q;
         p2_mask_q <= p1_mask_q;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         credit_q  <= credit_d;
      end
   end

   for (genvar gi = 0; gi < P; gi++) begin : g_lane
      mmm_lane #(
         .INW  (INW),
         .OUTW (OUTW)
      ) u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .in_valid (sb_q[MEM_LAT].valid),
         .in_clear (sb_q[MEM_LAT].clear),
         .a_in     (a_data),
         .b_in     (b_data[gi*INW +: INW]),
         .acc_out  (acc[gi])
      );
      assign wr_idx[gi] = wrap_add(wr_ptr_q, CW'(gi));
   end

   // Active lanes are always the low-numbered ones, so lane j lands at wr_ptr+j.
   always_ff @(posedge clk) begin
      for (int j = 0; j < P; j++) begin
         if (do_write && p2_mask_q[j]) mem_q[wr_idx[j]] <= acc[j];
      end
   end

   assign OUTPUT_TDATA     = mem_q[rd_ptr_q];
   assign OUTPUT_TVALID    = (count_q != '0);
   assign a_addr           = a_addr_q;
   assign b_addr           = b_addr_q;
   assign compute_finished = cf_q;
   assign busy             = busy_q;

endmodule

// File: doc/mmm_par.md
# mmm_par

Parametrised successor to the matrix-matrix multiply top. It computes C = A·B for an M×K by K×N signed matrix pair using P parallel MAC lanes, producing P adjacent output columns per dot-product pass. It sits between the input memories, which provide one A read port and one P-wide interleaved B read port, and the AXI-Stream output. Compared with the previous generation, it adds configurable lane count, a ragged last column group, a read-latency parameter, credit-based output backpressure, and a pipeline drain before handshake.

## Interface
- INW, 12: signed element width of A and B
- OUTW, 32: accumulator and output width
- M, 7: rows of A and C
- N, 9: columns of B and C
- MAXK, 8: maximum inner dimension
- P, 4: MAC lanes (1 ≤ P ≤ N)
- MEM_LAT, 1: input-memory read latency in cycles (≥1)
- OUT_DEPTH, 2·P: output buffer entries (≥P)
- clk, in, 1: sole clock, rising edge
- reset_n, in, 1: asynchronous, active-low reset
- matrices_loaded, in, 1: A/B valid in memory; held until compute_finished is seen
- K, in, $clog2(MAXK+1): inner dimension, sampled on IDLE→RUN
- compute_finished, out, 1: one-cycle pulse after the last C element enters the buffer
- a_addr, out, $clog2(M·MAXK): A address, row-major (row·K + k)
- a_data, in, INW: A read data, MEM_LAT cycles after a_addr
- b_addr, out, $clog2(MAXK·⌈N/P⌉): B group address (k·⌈N/P⌉ + group)
- b_data, in, P·INW: lane j in bits [j·INW +: INW], column group·P+j
- OUTPUT_TDATA, out, OUTW: C element, row-major
- OUTPUT_TVALID, out, 1: output valid
- OUTPUT_TREADY, in, 1: downstream ready
- busy, out, 1: high in any state other than IDLE

## Operation
- States:
  - IDLE: wait for matrices_loaded=1, then go to RUN.
  - RUN: issue one (k, row, group) read per cycle when permitted.
  - DRAIN: entered after the final read issues; wait for the lane pipeline and credit reservations to settle, pulse compute_finished, then go to DONE.
  - DONE: wait for matrices_loaded=0, then go to IDLE.
- K=0 on entry: go IDLE→DONE directly, pulse compute_finished once, and emit no data.
- Counters: k in 0..K-1 (innermost), then group in 0..⌈N/P⌉-1, then row in 0..M-1.
- Active lanes per group: P, except the last group, which has N−P·(⌈N/P⌉−1). Inactive lanes compute but their results are never written.
- Credits:
  - The counter starts at OUT_DEPTH.
  - A group's k=0 read issues only if credits ≥ its active-lane count. Those credits are subtracted at issue.
  - One credit is returned per OUTPUT_TVALID&TREADY beat.
  - Reads with k>0 never stall. A group, once started, runs to completion with no bubbles.
- Control sideband (valid, clear, last, lane mask) travels with each read through a shift register of depth MEM_LAT+1.
- Lanes:
  - Each stage registers the signed INW×INW product (2·INW bits), sign-extended or truncated to OUTW.
  - The accumulator is acc = clear ? prod : acc+prod. It wraps two's-complement, with no saturation.
- On the `last` beat, active lane results are written into the buffer in lane order. The buffer accepts up to P writes in one cycle and reads out one per cycle.
- A sub-P final group writes only active lanes. Output order is strictly row-major.

## Timing
- Reset (reset_n=0, any cycle):
  - State→IDLE; all counters, credits=OUT_DEPTH, pipeline valids, and buffer pointers are cleared.
  - Outputs go low: OUTPUT_TVALID, compute_finished, busy. a_addr and b_addr go to 0.
  - In-flight results are discarded.
- Addresses are registered outputs, first driven in the first RUN cycle.
- Latency from a group's last read issue to its first result on OUTPUT_TDATA: MEM_LAT+3 cycles (with an empty buffer and TREADY=1).
- A full run without stalls takes ⌈N/P⌉·M·K issue cycles.
- AXIS rules:
  - TDATA/TVALID stay stable while TVALID&!TREADY.
  - Once asserted, TVALID is not dropped until the beat transfers.
  - There is no combinational path from TREADY to TVALID.
- Simultaneous buffer write and read in one cycle are both honoured. The buffer can never overflow, by credit construction.
- compute_finished is asserted exactly once per run, and not before the last element is written. It is independent of downstream drain.

## Structure
- mmm_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - localparams for the group count ⌈N/P⌉ and the last-group lane count;
  - a clog2-safe width function used for all address and counter widths.
- Sub-module mmm_lane: one registered multiply plus accumulator with valid/clear inputs. It is instantiated P times via generate.
- The output buffer and credit counter are inline in mmm_par.

## Test plan
- M=2, N=4, P=4, K=3, A=1..6 row-major, B=all 1, TREADY=1 → 8 beats, 6,6,6,6,15,15,15,15; one compute_finished pulse.
- N=9, P=4 (groups 4,4,1), K=2, random ±2047 → 63 beats, row-major, matching the reference model.
- Same as above with TREADY random at 30% → identical stream. Credits never go below 0, and a group's k=0 issue is withheld until credits ≥ its active-lane count.
- A=−2048 and B=−2048 everywhere, K=8, OUTW=32 → each element is 33554432. With OUTW=24, the result wraps to 0.
- K=0 → no beats, compute_finished pulses once, and the block returns to IDLE only after matrices_loaded falls.
- reset_n low mid-RUN with the buffer half full → TVALID low immediately (asynchronously), and a subsequent run produces correct results from scratch.
